// File: rtl/fb_pixel_writer.sv
// Consumer end of the rasterizer pixel FIFO: pops colour/coordinate pairs, converts
// to RGB565, clips off-screen pixels and writes the rest to framebuffer memory.
module fb_pixel_writer #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_empty,
  output logic              pix_rd_en,
  input  logic [31:0]       pix_data,
  input  logic              crd_empty,
  output logic              crd_rd_en,
  input  logic [31:0]       crd_data,
  input  logic              clear_start,
  input  logic [23:0]       clear_color,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              fifo_ready,
  output logic              busy,
  output logic [15:0]       drop_count
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam int               LIN_W      = ADDR_W + 16;
  localparam int               NPIX       = FB_WIDTH * FB_HEIGHT;
  localparam int               CNT_W      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(NPIX - 1);
  localparam logic [16:0]      X_LIM      = 17'(FB_WIDTH);
  localparam logic [16:0]      Y_LIM      = 17'(FB_HEIGHT);

  function automatic logic [15:0] to_rgb565(input logic [4:0] r, input logic [5:0] g,
                                            input logic [4:0] b);
    return {r, g, b};
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [ADDR_W-1:0] base_p0;
  logic              pop;
  logic [15:0]       x_p1;
  logic [15:0]       y_p1;
  logic              clip_p1;
  logic [LIN_W-1:0]  lin_p1;
  logic              unused_bits;

  // Pop only when idle, no clear is requested and both FIFOs can supply a word.
  assign pop       = rst_n && (state == S_IDLE) && !clear_start && !pix_empty && !crd_empty;
  assign pix_rd_en = pop;
  assign crd_rd_en = pop;
  assign busy      = (state != S_IDLE);

  // Stage p1: popped words are on the FIFO outputs while in LATCH.
  assign x_p1    = crd_data[15:0];
  assign y_p1    = crd_data[31:16];
  assign clip_p1 = ({1'b0, x_p1} >= X_LIM) || ({1'b0, y_p1} >= Y_LIM);
  assign lin_p1  = LIN_W'(base_p0) + LIN_W'(y_p1) * LIN_W'(FB_WIDTH) + LIN_W'(x_p1);

  assign unused_bits = ^{pix_data[31:24], pix_data[18:16], pix_data[9:8], pix_data[2:0],
                         clear_color[18:16], clear_color[9:8], clear_color[2:0],
                         lin_p1[LIN_W-1:ADDR_W]};

  // Stage p0: base address captured alongside the pop.
  always_ff @(posedge clk) begin
    if (pop) base_p0 <= fb_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      drop_count <= '0;
      fifo_ready <= 1'b0;
    end else begin
      fifo_ready <= 1'b1;
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= fb_base;
            mem_wdata  <= to_rgb565(clear_color[23:19], clear_color[15:10], clear_color[7:3]);
            fifo_ready <= 1'b0;
          end else if (pop) begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (clip_p1) begin
            state <= S_IDLE;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
          end else begin
            state     <= S_WRITE;
            mem_req   <= 1'b1;
            mem_addr  <= lin_p1[ADDR_W-1:0];
            mem_wdata <= to_rgb565(pix_data[23:19], pix_data[15:10], pix_data[7:3]);
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_CLEAR: begin
          // Request stays asserted across beats; address advances on every ack.
          if (mem_ack && (clr_cnt == CLEAR_LAST)) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end else begin
            fifo_ready <= 1'b0;
            if (mem_ack) begin
              clr_cnt  <= clr_cnt + 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a write scoreboard and FIFO model.
module tb_fb_pixel_writer;
  localparam int FB_W = 640;
  localparam int FB_H = 48;
  localparam int AW   = 20;
  localparam int NPIX = FB_W * FB_H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_empty = 1'b1;
  logic          pix_rd_en;
  logic [31:0]   pix_data = '0;
  logic          crd_empty = 1'b1;
  logic          crd_rd_en;
  logic [31:0]   crd_data = '0;
  logic          clear_start = 1'b0;
  logic [23:0]   clear_color = '0;
  logic [AW-1:0] fb_base = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic          fifo_ready;
  logic          busy;
  logic [15:0]   drop_count;

  fb_pixel_writer #(.FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_empty(pix_empty), .pix_rd_en(pix_rd_en), .pix_data(pix_data),
    .crd_empty(crd_empty), .crd_rd_en(crd_rd_en), .crd_data(crd_data),
    .clear_start(clear_start), .clear_color(clear_color), .fb_base(fb_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .fifo_ready(fifo_ready), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          clr;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  wr_t           exp_q[$];
  logic [31:0]   pix_q[$];
  logic [31:0]   crd_q[$];
  int            pix_pops = 0, crd_pops = 0;
  int            writes = 0, clear_writes = 0, clear_left = 0, exp_drops = 0;
  int            stall = 0;
  logic          chk_en = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_data = '0;
  logic          pp, cp;
  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [15:0]   prev_data;
  wr_t           cmp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain arithmetic on channels and coordinates.
  function automatic logic [15:0] m_565(input logic [31:0] c);
    int r, g, b;
    r = int'((c >> 16) % 256) / 8;
    g = int'((c >> 8) % 256) / 4;
    b = int'(c % 256) / 8;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  function automatic logic [AW-1:0] m_addr(input logic [AW-1:0] base, input int y, input int x);
    longint a;
    a = longint'(base) + longint'(y) * FB_W + longint'(x);
    return AW'(a % (longint'(1) << AW));
  endfunction

  task automatic model_pixel(input int y, input int x, input logic [31:0] color);
    wr_t e;
    if (x >= FB_W || y >= FB_H) exp_drops++;
    else begin
      e.addr = m_addr(fb_base, y, x);
      e.data = m_565(color);
      e.clr  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int y, input int x, input logic [31:0] color);
    model_pixel(y, x, color);
    pix_q.push_back(color);
    crd_q.push_back({16'(y), 16'(x)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    checks++;
    while (!(pix_q.size() == 0 && crd_q.size() == 0 && pix_empty && crd_empty &&
             !busy && !mem_req && exp_q.size() == 0)) begin
      tick(1);
      k++;
      if (k > budget) begin
        errors++;
        $display("FAIL %s timeout after %0d cycles, required idle", name, k);
        return;
      end
    end
  endtask

  task automatic wait_req(input string name, input int budget);
    int k;
    k = 0;
    checks++;
    while (!mem_req) begin
      tick(1);
      k++;
      if (k > budget) begin
        errors++;
        $display("FAIL %s timeout waiting for mem_req=1", name);
        return;
      end
    end
  endtask

  // FIFO model: a pop seen during a cycle delivers data just after the next edge.
  always @(negedge clk) begin
    pp = pix_rd_en;
    cp = crd_rd_en;
    @(posedge clk);
    #1;
    if (pp) begin
      pix_pops++;
      if (pix_q.size() > 0) pix_data = pix_q.pop_front();
    end
    if (cp) begin
      crd_pops++;
      if (crd_q.size() > 0) crd_data = crd_q.pop_front();
    end
    pix_empty = (pix_q.size() == 0);
    crd_empty = (crd_q.size() == 0);
  end

  // Memory responder: acks every request unless a stall is pending.
  always @(posedge clk) begin
    #3;
    if (mem_req && stall > 0) begin
      mem_ack = 1'b0;
      stall--;
    end else begin
      mem_ack = mem_req;
    end
  end

  // Per-cycle comparison against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n || !chk_en) begin
      prev_hold = 1'b0;
    end else begin
      check("fifo_ready", 32'(fifo_ready), 32'(clear_left == 0));
      if (pix_rd_en || crd_rd_en) begin
        check("joint_pop", 32'(pix_rd_en), 32'(crd_rd_en));
        check("pop_legal", 32'(mem_req || clear_left > 0 || pix_empty || crd_empty), 32'd0);
      end
      if (prev_hold) begin
        check("hold_req", 32'(mem_req), 32'd1);
        check("hold_addr", 32'(mem_addr), 32'(prev_addr));
        check("hold_data", 32'(mem_wdata), 32'(prev_data));
      end
      if (mem_req && mem_ack) begin
        writes++;
        last_addr = mem_addr;
        last_data = mem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required=none", mem_addr, mem_wdata);
        end else begin
          cmp_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(cmp_e.addr));
          check("wr_data", 32'(mem_wdata), 32'(cmp_e.data));
          if (cmp_e.clr) begin
            clear_writes++;
            clear_left--;
          end
        end
      end
      prev_hold = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0;
    wr_t e;
    tick(3);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rd_en", 32'(pix_rd_en | crd_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_ready", 32'(fifo_ready), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("ready_after_rst", 32'(fifo_ready), 32'd1);
    chk_en = 1'b1;

    // Single in-range pixel with immediate ack.
    fb_base = 20'h01000;
    p0 = pix_pops; w0 = writes;
    send(2, 3, 32'h00FC8040);
    wait_idle("single", 50);
    check("single_pix_pops", 32'(pix_pops - p0), 32'd1);
    check("single_crd_pops", 32'(crd_pops - p0), 32'd1);
    check("single_writes", 32'(writes - w0), 32'd1);
    check("single_addr", 32'(last_addr), 32'h1503);
    check("single_data", 32'(last_data), 32'hFC08);

    // Clipped coordinates on both axes, then edge-of-screen pixel.
    p0 = pix_pops; w0 = writes;
    send(0, 640, 32'h00FFFFFF);
    send(480, 0, 32'h00FFFFFF);
    send(FB_H, 0, 32'h00FFFFFF);
    send(FB_H - 1, FB_W - 1, 32'h00123456);
    wait_idle("clip", 100);
    check("clip_drops", 32'(drop_count), 32'd3);
    check("clip_drops_model", 32'(drop_count), 32'(exp_drops));
    check("clip_pops", 32'(pix_pops - p0), 32'd4);
    check("clip_writes", 32'(writes - w0), 32'd1);
    check("edge_addr", 32'(last_addr), 32'h87FF);
    check("edge_data", 32'(last_data), 32'h11AA);

    // Address wraps past the top of the ADDR_W space.
    fb_base = 20'hFFFF0;
    send(0, 32, 32'h00FFFFFF);
    wait_idle("wrap", 50);
    check("wrap_addr", 32'(last_addr), 32'h00010);
    check("wrap_data", 32'(last_data), 32'hFFFF);

    // Withheld ack: outputs held, no pops while outstanding.
    fb_base = '0;
    stall = 5;
    p0 = pix_pops;
    send(1, 1, 32'h0000FF00);
    wait_req("stall_req", 20);
    send(0, 5, 32'h00FF0000);
    tick(3);
    check("stall_req_held", 32'(mem_req), 32'd1);
    check("stall_no_pop", 32'(pix_pops - p0), 32'd1);
    check("stall_addr", 32'(mem_addr), 32'h281);
    check("stall_data", 32'(mem_wdata), 32'h07E0);
    wait_idle("stall", 60);
    check("stall_pops", 32'(pix_pops - p0), 32'd2);
    check("stall_last_addr", 32'(last_addr), 32'd5);
    check("stall_last_data", 32'(last_data), 32'hF800);

    // Only the colour FIFO has data: no pop until coordinates arrive.
    p0 = pix_pops;
    model_pixel(0, 9, 32'h000000F8);
    pix_q.push_back(32'h000000F8);
    tick(10);
    check("onesided_no_pop", 32'(pix_pops - p0), 32'd0);
    check("onesided_busy", 32'(busy), 32'd0);
    crd_q.push_back({16'd0, 16'd9});
    wait_idle("onesided", 50);
    check("onesided_pops", 32'(pix_pops - p0), 32'd1);
    check("onesided_addr", 32'(last_addr), 32'd9);
    check("onesided_data", 32'(last_data), 32'h001F);

    // Clear has priority over a pair that becomes available in the same cycle.
    fb_base = '0;
    clear_color = 24'hFC00FC;
    p0 = pix_pops;
    for (int i = 0; i < NPIX; i++) begin
      e.addr = AW'(i);
      e.data = m_565({8'h00, clear_color});
      e.clr  = 1'b1;
      exp_q.push_back(e);
    end
    send(3, 7, 32'h00808080);
    tick(1);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    clear_left = NPIX;
    tick(100);
    check("clear_ready_low", 32'(fifo_ready), 32'd0);
    check("clear_wdata", 32'(mem_wdata), 32'hF81F);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    wait_idle("clear", NPIX + 200);
    check("clear_count", 32'(clear_writes), 32'(NPIX));
    check("clear_then_pop", 32'(pix_pops - p0), 32'd1);
    check("clear_pix_addr", 32'(last_addr), 32'h787);
    check("clear_pix_data", 32'(last_data), 32'h8410);
    check("clear_ready_back", 32'(fifo_ready), 32'd1);

    // Asynchronous reset in the middle of an outstanding write.
    stall = 1000;
    send(4, 4, 32'h00FFFFFF);
    wait_req("rst_req", 20);
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_ready", 32'(fifo_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    stall = 0;
    chk_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_en = 1'b1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_drop", 32'(drop_count), 32'd0);
    check("post_rst_ready", 32'(fifo_ready), 32'd1);
    check("post_rst_req", 32'(mem_req), 32'd0);
    exp_drops = 0;
    send(0, 0, 32'h00FC8040);
    wait_idle("post_rst", 50);
    check("post_rst_addr", 32'(last_addr), 32'd0);
    check("post_rst_data", 32'(last_data), 32'hFC08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Consumer end of the rasterizer's pixel FIFO.
- Pops a colour word and a matching coordinate word each time both FIFOs hold data.
- Converts the colour to RGB565, computes the linear framebuffer address, clips anything off-screen, and writes the pixel to framebuffer memory over a req/ack port.
- Also performs a framebuffer clear on command, and signals the rasterizer through `fifo_ready` when it may start emitting pixels.

Parameters:
- FB_WIDTH, 640, framebuffer width in pixels.
- FB_HEIGHT, 480, framebuffer height in pixels.
- ADDR_W, 20, memory word address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_empty  in  1  pixel FIFO empty.
- pix_rd_en  out  1  pixel FIFO pop; data valid the cycle after.
- pix_data  in  32  colour word. [31:24] reserved; R=[23:16], G=[15:8], B=[7:0].
- crd_empty  in  1  coordinate FIFO empty.
- crd_rd_en  out  1  coordinate FIFO pop; data valid the cycle after.
- crd_data  in  32  {y[31:16], x[15:0]}, unsigned.
- clear_start  in  1  one-cycle pulse requesting a framebuffer clear.
- clear_color  in  24  RGB888 clear colour, sampled on clear_start.
- fb_base  in  ADDR_W  framebuffer base word address, sampled at each pop and at clear_start.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  RGB565 write data.
- mem_ack  in  1  memory accepted the current request.
- fifo_ready  out  1  rasterizer may emit pixels.
- busy  out  1  any state other than IDLE.
- drop_count  out  16  saturating count of clipped pixels.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - pix_rd_en, crd_rd_en, mem_req, busy, fifo_ready = 0.
  - mem_addr, mem_wdata, drop_count = 0.
  - Takes effect immediately, including mid-request. The pending write is abandoned; the held FIFO word is discarded.
- `fifo_ready` = 1 in every state except CLEAR. It is 0 during reset and drops the cycle after clear_start is accepted.
- Colour conversion: mem_wdata = {R[7:3], G[7:2], B[7:3]}.
- Address: fb_base + y*FB_WIDTH + x, computed in ADDR_W+16 bits and truncated to ADDR_W.
- Clip rule: x >= FB_WIDTH or y >= FB_HEIGHT.
  - No mem_req is issued.
  - drop_count increments, saturating at 0xFFFF.
- States:
  - IDLE:
    - clear_start=1 -> latch clear_color(565) and fb_base, clear counter=0, go to CLEAR. clear_start has priority over pending FIFO data.
    - Otherwise, if !pix_empty && !crd_empty -> pulse pix_rd_en and crd_rd_en together for exactly one cycle, go to LATCH.
    - If only one FIFO is non-empty -> no pop, stay in IDLE.
  - LATCH: capture pix_data/crd_data and evaluate the clip rule.
    - Clipped -> IDLE.
    - Else -> WRITE, driving mem_req=1 with addr/data.
  - WRITE: mem_req, mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
    - Then mem_req=0 the next cycle and return to IDLE.
    - Minimum 3 cycles per pixel: pop, latch, write.
  - CLEAR: issue sequential writes for addr = base .. base + FB_WIDTH*FB_HEIGHT - 1, one per ack.
    - mem_req may stay high back-to-back across acked beats.
    - After the last ack -> IDLE.
- mem_ack while mem_req=0 is ignored.
- clear_start outside IDLE is ignored (not queued).
- FIFO data is never popped while a write is outstanding or during CLEAR.

Test Plan:
- clear_start with clear_color=0xFC00FC, fb_base=0 -> 307200 writes, mem_wdata=0xF81F, addr 0..307199 in order; fifo_ready=0 throughout, =1 the cycle after returning to IDLE.
- crd_data={y=2,x=3}, pix_data=0x00FC8040, fb_base=0x1000, mem_ack immediate -> single write addr=0x1503, wdata=0xFC08; exactly one pop pulse on each FIFO.
- crd_data={y=0,x=640}, then {y=480,x=0} -> no mem_req; drop_count=2; block returns to IDLE and pops the next pair.
- mem_ack withheld 5 cycles during a write -> mem_addr/mem_wdata stable; no pops; then IDLE after the ack.
- pix_empty=0, crd_empty=1 held 10 cycles -> pix_rd_en and crd_rd_en stay 0; raising crd data triggers one joint pop.
- rst_n low while in WRITE with mem_req=1 -> mem_req=0 immediately (same cycle, asynchronous); after release state=IDLE, drop_count=0, fifo_ready=1.
